dht11_sched: RTL
================

# dht11_sched

Measurement scheduler for the DHT11 sensor peripheral. Sits between the APB slave register file and the DHT11 capture IP. Arbitrates software-triggered and periodic auto-poll requests onto the single sensor. Enforces the sensor's minimum inter-measurement gap, applies a response timeout, and latches validated humidity/temperature results with sticky error status.

## Interface
- TICK_DIV, 100_000: PCLK cycles per 1 ms tick (1 ms at 100 MHz).
- MIN_GAP_MS, 2000: minimum ms between consecutive dht_start pulses.
- TIMEOUT_MS, 50: ms allowed from dht_start to dht_done.
- PCLK  in  1  clock; one clock, all logic on rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- sw_req  in  1  single-cycle software measurement request.
- auto_en  in  1  enable periodic polling.
- auto_period  in  16  auto-poll period in ms; values below MIN_GAP_MS (including 0) are treated as MIN_GAP_MS.
- dht_start  out  1  single-cycle start pulse to the DHT11 IP.
- dht_done  in  1  single-cycle frame-complete pulse from the IP.
- dht_valid  in  1  checksum OK; qualified by dht_done.
- dht_humidity  in  16  raw humidity, sampled on dht_done.
- dht_temperature  in  16  raw temperature, sampled on dht_done.
- hum_q  out  16  last valid humidity.
- temp_q  out  16  last valid temperature.
- data_valid  out  1  at least one valid result since reset.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky; last measurement timed out.
- err_csum  out  1  sticky; last measurement had a bad checksum.
- last_src  out  1  source of the last start: 1 = software, 0 = auto.
- meas_cnt  out  16  count of valid results; wraps 0xFFFF -> 0.

## Operation
- Reset value: all outputs 0. FSM goes to IDLE, pend_sw/pend_auto are cleared, timers are cleared. No gap is enforced after reset.
- Request capture:
  - sw_req sets pend_sw.
  - The auto timer is a free-running ms counter, held at 0 while auto_en=0. When it reaches the effective period, it sets pend_auto and restarts from 0.
  - Multiple requests before service coalesce into one.
- FSM states:
  - IDLE: if sw_req, pend_sw or pend_auto -> START.
  - START: dht_start=1; clear the measurement prescaler and ms counter; clear both pend flags; set last_src=1 if any software request was pending, else 0 (software wins when both are pending) -> WAIT.
  - WAIT: on dht_done -> GAP. If dht_valid=1: latch hum_q/temp_q, set data_valid, increment meas_cnt, clear err_timeout and err_csum. If dht_valid=0: set err_csum, leave data unchanged. If the ms counter reaches TIMEOUT_MS without dht_done: set err_timeout -> GAP.
  - GAP: when the ms counter reaches MIN_GAP_MS -> START if any request is pending, else IDLE.
- dht_done outside WAIT is ignored.
- Requests arriving in START/WAIT/GAP are held in pend flags and serviced after GAP.
- dht_done and timeout in the same cycle: done wins; no timeout is flagged.

## Timing
- S is the cycle in which dht_start=1.
- sw_req sampled in cycle N while in IDLE -> dht_start in cycle N+1.
- dht_done in cycle M -> hum_q/temp_q/flags/meas_cnt updated and visible in M+1.
- Timeout flag visible in S + TIMEOUT_MS·TICK_DIV + 1.
- GAP exits in S + MIN_GAP_MS·TICK_DIV + 1. This cycle is the next dht_start if a request is pending; otherwise busy=0 in this cycle.
- dht_start is never high for two consecutive cycles.
- PRESET asserted in any state: outputs read 0 the next cycle; an in-flight measurement is abandoned.

## Structure
- Shared package dht11_pkg: state enum (IDLE, START, WAIT, GAP) and source constants SRC_SW/SRC_AUTO.
- Sub-module dht11_ms_tick: prescaler producing a 1-cycle ms tick, with synchronous clear. Instantiated twice: once for the auto timer (free-running) and once for the measurement timer (cleared in START).

## Test plan
All scenarios use TICK_DIV=10, MIN_GAP_MS=5, TIMEOUT_MS=3.
- Basic read: reset, sw_req at cycle 10 -> dht_start only at cycle 11. Drive dht_done at 30 with dht_valid=1, hum=0x3700, temp=0x1900 -> at 31: hum_q=0x3700, temp_q=0x1900, data_valid=1, meas_cnt=1, last_src=1. busy=0 at 62.
- Gap enforcement: as above, plus sw_req at cycles 40 and 45 -> exactly one further dht_start, at cycle 62; busy stays 1 throughout.
- Timeout: sw_req at 10, no dht_done -> err_timeout=1 at 42, hum_q unchanged. dht_done at 50 is ignored. A following valid measurement clears err_timeout.
- Bad checksum: dht_done with dht_valid=0 -> err_csum=1; hum_q, temp_q and meas_cnt unchanged.
- Auto poll:
  - auto_en=1, auto_period=8 with the IP answering each start -> dht_start spaced 80 cycles, last_src=0.
  - auto_period=2 -> spacing clamped to ≥50 cycles.
  - sw_req coincident with auto expiry -> one start, last_src=1.
- Reset mid-WAIT: PRESET for 1 cycle -> all outputs 0 next cycle. A late dht_done has no effect. A new sw_req gives dht_start on the following cycle.

Source files
------------

// File: rtl/dht11_pkg.sv
// -----------------------------------------------------------------------------
// dht11_pkg
// Shared types and constants for the DHT11 measurement scheduler.
//   state_t  : scheduler FSM states
//   SRC_SW   : last_src encoding for a software-triggered start
//   SRC_AUTO : last_src encoding for an auto-poll start
// -----------------------------------------------------------------------------
package dht11_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic SRC_SW   = 1'b1;
  localparam logic SRC_AUTO = 1'b0;

endpackage

// File: rtl/dht11_ms_tick.sv
// -----------------------------------------------------------------------------
// dht11_ms_tick
// Prescaler producing a single-cycle tick every TICK_DIV clock cycles.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_clr  : synchronous clear; counter restarts and the tick is suppressed
//   o_tick : high for one cycle at the end of every TICK_DIV-cycle period
// -----------------------------------------------------------------------------
module dht11_ms_tick #(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/dht11_sched.sv
// -----------------------------------------------------------------------------
// dht11_sched
// Measurement scheduler between the APB register file and the DHT11 capture
// IP. Merges software and periodic auto-poll requests, issues one start pulse
// per measurement, enforces the minimum gap between starts, times out silent
// frames and latches validated results with sticky error flags.
// Ports:
//   i_pclk, i_preset        : clock / synchronous active-high reset
//   i_sw_req                : 1-cycle software request
//   i_auto_en, i_auto_period: periodic poll enable and period in ms
//   o_dht_start             : 1-cycle start pulse to the capture IP
//   i_dht_done, i_dht_valid : frame complete / checksum OK from the IP
//   i_dht_humidity/temperature : raw frame data, sampled on done
//   o_hum_q, o_temp_q       : last valid result
//   o_data_valid            : a valid result has been seen since reset
//   o_busy                  : FSM not idle
//   o_err_timeout, o_err_csum : sticky error flags, cleared by a valid result
//   o_last_src              : source of the last start (SRC_SW / SRC_AUTO)
//   o_meas_cnt              : valid-result counter, wraps
// -----------------------------------------------------------------------------
module dht11_sched
  import dht11_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000,
  parameter int unsigned MIN_GAP_MS = 2000,
  parameter int unsigned TIMEOUT_MS = 50
) (
  input  logic        i_pclk,
  input  logic        i_preset,
  input  logic        i_sw_req,
  input  logic        i_auto_en,
  input  logic [15:0] i_auto_period,
  output logic        o_dht_start,
  input  logic        i_dht_done,
  input  logic        i_dht_valid,
  input  logic [15:0] i_dht_humidity,
  input  logic [15:0] i_dht_temperature,
  output logic [15:0] o_hum_q,
  output logic [15:0] o_temp_q,
  output logic        o_data_valid,
  output logic        o_busy,
  output logic        o_err_timeout,
  output logic        o_err_csum,
  output logic        o_last_src,
  output logic [15:0] o_meas_cnt
);

  localparam logic [15:0] MIN_GAP  = 16'(MIN_GAP_MS);
  localparam logic [15:0] GAP_LAST = 16'(MIN_GAP_MS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_MS - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_pend_sw;
  logic        r_pend_auto;
  logic [15:0] r_auto_ms;
  logic [15:0] r_meas_ms;
  logic [15:0] r_hum;
  logic [15:0] r_temp;
  logic [15:0] r_cnt;
  logic        r_data_valid;
  logic        r_err_timeout;
  logic        r_err_csum;
  logic        r_last_src;

  logic        w_auto_tick;
  logic        w_meas_tick;
  logic        w_auto_hit;
  logic        w_timeout_hit;
  logic        w_gap_hit;
  logic        w_req_now;
  logic [15:0] w_eff_period;

  // Auto timer prescaler only runs while polling is enabled.
  dht11_ms_tick #(.TICK_DIV(TICK_DIV)) u_auto_tick (
    .i_clk  (i_pclk),
    .i_rst  (i_preset),
    .i_clr  (!i_auto_en),
    .o_tick (w_auto_tick)
  );

  // Measurement prescaler is re-phased at every start so timeout and gap are
  // measured from the start pulse itself.
  dht11_ms_tick #(.TICK_DIV(TICK_DIV)) u_meas_tick (
    .i_clk  (i_pclk),
    .i_rst  (i_preset),
    .i_clr  (r_state == START),
    .o_tick (w_meas_tick)
  );

  assign w_eff_period  = (i_auto_period < MIN_GAP) ? MIN_GAP : i_auto_period;
  // >= rather than == so a period lowered mid-count expires instead of wrapping.
  assign w_auto_hit    = w_auto_tick && (r_auto_ms >= w_eff_period - 16'd1);
  assign w_timeout_hit = w_meas_tick && (r_meas_ms == TMO_LAST);
  assign w_gap_hit     = w_meas_tick && (r_meas_ms >= GAP_LAST);
  assign w_req_now     = i_sw_req || r_pend_sw || r_pend_auto;

  // Timers and request capture.
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_auto_ms   <= '0;
      r_meas_ms   <= '0;
      r_pend_sw   <= 1'b0;
      r_pend_auto <= 1'b0;
    end else begin
      if (!i_auto_en || w_auto_hit) begin
        r_auto_ms <= '0;
      end else if (w_auto_tick) begin
        r_auto_ms <= r_auto_ms + 16'd1;
      end

      if (r_state == START) begin
        r_meas_ms <= '0;
      end else if (w_meas_tick && r_meas_ms != 16'hFFFF) begin
        r_meas_ms <= r_meas_ms + 16'd1;
      end

      // START consumes the pending requests; a request landing in that same
      // cycle belongs to the next measurement and must survive.
      if (r_state == START) begin
        r_pend_sw   <= i_sw_req;
        r_pend_auto <= w_auto_hit;
      end else begin
        r_pend_sw   <= r_pend_sw   || i_sw_req;
        r_pend_auto <= r_pend_auto || w_auto_hit;
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    o_dht_start = 1'b0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_req_now) w_next = START;
      end
      START: begin
        o_dht_start = 1'b1;
        w_next      = WAIT;
      end
      WAIT: begin
        // done has priority over a coincident timeout
        if (i_dht_done || w_timeout_hit) w_next = GAP;
      end
      GAP: begin
        if (w_gap_hit) w_next = w_req_now ? START : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Result and status registers.
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_hum         <= '0;
      r_temp        <= '0;
      r_cnt         <= '0;
      r_data_valid  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_csum    <= 1'b0;
      r_last_src    <= SRC_AUTO;
    end else begin
      case (r_state)
        START: r_last_src <= r_pend_sw ? SRC_SW : SRC_AUTO;
        WAIT: begin
          if (i_dht_done) begin
            if (i_dht_valid) begin
              r_hum         <= i_dht_humidity;
              r_temp        <= i_dht_temperature;
              r_cnt         <= r_cnt + 16'd1;
              r_data_valid  <= 1'b1;
              r_err_timeout <= 1'b0;
              r_err_csum    <= 1'b0;
            end else begin
              r_err_csum <= 1'b1;
            end
          end else if (w_timeout_hit) begin
            r_err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hum_q       = r_hum;
  assign o_temp_q      = r_temp;
  assign o_meas_cnt    = r_cnt;
  assign o_data_valid  = r_data_valid;
  assign o_err_timeout = r_err_timeout;
  assign o_err_csum    = r_err_csum;
  assign o_last_src    = r_last_src;

endmodule
